// File: rtl/serial_sub_8.sv
// Bit-serial subtractor: diff = A - B - bin over WIDTH cycles using one
// full-subtractor cell, LSB first, with a start/busy/done handshake.
module serial_sub_8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic [1:0]       dbg_state
);

  // Handshake: start is taken only in IDLE (operands captured on that edge);
  // busy marks the WIDTH shift cycles; done is a one-cycle pulse while diff/bout
  // hold the new result. Starts seen while busy or done are dropped, not queued.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] d_sr_q, d_sr_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             a0, b0, d_bit, br_nx;
  logic [WIDTH-1:0] d_sr_nx;

  // Full-subtractor cell on the current LSBs.
  assign a0      = a_sr_q[0];
  assign b0      = b_sr_q[0];
  assign d_bit   = a0 ^ b0 ^ br_q;
  assign br_nx   = (~a0 & b0) | (~(a0 ^ b0) & br_q);
  assign d_sr_nx = {d_bit, d_sr_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    d_sr_d  = d_sr_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d  = A;
          b_sr_d  = B;
          br_d    = bin;
          cnt_d   = '0;
          d_sr_d  = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        br_d   = br_nx;
        d_sr_d = d_sr_nx;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          diff_d  = d_sr_nx;
          bout_d  = br_nx;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      d_sr_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      d_sr_q  <= d_sr_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy      = (state_q == S_SHIFT);
  assign done      = (state_q == S_DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign dbg_state = state_q;

endmodule

// File: doc/serial_sub_8.md
Name: serial_sub_8

Overview:
- Bit-serial subtractor; the inverse operation of the team's 8-bit ripple-carry adder.
- Computes diff = A - B - bin over WIDTH clock cycles, using one full-subtractor cell, operand shift registers and a borrow flop.
- Uses a start/busy/done handshake and sits beside the combinational adder in the ALU datapath.
- Results are checked against the adder: A == diff + B + bin, with bout as the wrap indicator.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 2.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend, unsigned; captured on accepted start.
- B  input  WIDTH  subtrahend, unsigned; captured on accepted start.
- bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while an operation is in progress (state SHIFT).
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  result register, (A - B - bin) mod 2^WIDTH.
- bout  output  1  borrow-out; 1 iff A < B + bin (unsigned).

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - state = IDLE.
  - busy, done, bout = 0; diff = 0.
  - Internal shift registers, borrow flop and bit counter = 0.
- States: IDLE, SHIFT, DONE. Encoding is free; must be registered.
- IDLE:
  - On a rising edge with start = 1: load a_sr <= A, b_sr <= B, br <= bin, cnt <= 0, d_sr <= 0; go to SHIFT.
  - start = 0: stay in IDLE.
- SHIFT, each edge processes bit a_sr[0], b_sr[0]:
  - d = a_sr[0] ^ b_sr[0] ^ br.
  - br <= (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br).
  - d_sr <= {d, d_sr[WIDTH-1:1]} (LSB first in, ends aligned).
  - a_sr and b_sr shift right by 1; cnt <= cnt + 1.
  - On the edge where cnt == WIDTH-1: diff <= final aligned d_sr, bout <= final borrow; go to DONE.
- DONE: done = 1 for exactly one cycle; unconditional transition to IDLE on the next edge.
- busy = (state == SHIFT); done = (state == DONE). Both are decoded from registered state, so they are glitch-free.
- Latency:
  - Start accepted at edge 0.
  - Bits processed at edges 1..WIDTH.
  - done high in the cycle following edge WIDTH.
  - busy high for exactly WIDTH cycles.
  - Next start is accepted no earlier than edge WIDTH+2; throughput is one op per WIDTH+2 cycles.
- diff and bout change only on entry to DONE. They hold the previous result during SHIFT and through IDLE until the next completion.
- start while in SHIFT or DONE is ignored; no queuing. Operand changes after capture have no effect.
- A, B and bin must be stable only at the accepting edge.
- Reset mid-operation aborts immediately; no done pulse. Outputs go to reset values.
- Boundary results:
  - A == B and bin = 0: diff = 0, bout = 0.
  - A = 0, B = 0, bin = 1: diff = all ones, bout = 1.

Test Plan:
- Reset, then A=120, B=240, bin=0, start pulse -> busy high 8 cycles; done pulse 8 cycles after accept; diff=136, bout=1.
- A=200, B=50, bin=1 -> diff=149, bout=0. A=255, B=255, bin=0 -> diff=0, bout=0. A=0, B=0, bin=1 -> diff=255, bout=1.
- Start A=53, B=250, bin=0; change A/B and pulse start during busy -> only one done pulse; diff=59, bout=1; the second start is ignored.
- Start A=50, B=100, then drop rst_n low after 3 busy cycles -> busy, done, diff, bout all 0 immediately; no done pulse. Release reset, start A=1, B=50, bin=1 -> diff=206, bout=1.
- Back-to-back: hold start high continuously -> ops accepted every 10 cycles. Each done has diff == (A-B-bin) mod 256, and diff + B + bin (through the 8-bit adder) returns A.
- Random sweep of 1000 vectors against the reference model A - B - bin -> zero mismatches; diff stable between done pulses.
